// File: rtl/uop_bus_reader.sv
// ---------------------------------------------------------------------------
// uop_bus_reader
//
// Reading end of a shared tri-state bus driven by N_SRC output-enabled
// latches. A scan enables one source at a time (ascending index, unset mask
// bits skipped at no cost). Each enable is held for SETTLE cycles, then the
// bus word is captured and presented with its source index.
//
// Optional feature (macro TURNAROUND_EN): insert one oe=0 cycle between
// consecutive sources so that two drivers never overlap on the bus.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   request a scan (accepted only while busy==0)
//   src_mask  in   sources to read, latched when start is accepted
//   bus       in   shared bus word (resolved)
//   oe        out  registered output enables, at most one bit high
//   busy      out  scan in progress
//   rd_valid  out  one-cycle pulse, rd_idx/rd_data carry a new sample
//   rd_idx    out  index of the sampled source
//   rd_data   out  sampled bus word (held until next capture)
//   done      out  one-cycle pulse, scan complete
// ---------------------------------------------------------------------------
module uop_bus_reader #(
   parameter  int N_SRC  = 4,
   parameter  int W      = 8,
   parameter  int SETTLE = 2,
   localparam int IDX_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [N_SRC-1:0]  src_mask,
   input  logic [W-1:0]      bus,
   output logic [N_SRC-1:0]  oe,
   output logic              busy,
   output logic              rd_valid,
   output logic [IDX_W-1:0]  rd_idx,
   output logic [W-1:0]      rd_data,
   output logic              done
);

   localparam int               CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ENABLE = 2'd1,
`ifdef TURNAROUND_EN
      ST_GAP    = 2'd3,
`endif
      ST_FINISH = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [IDX_W-1:0]   cur, cur_nxt;
   // rem holds the sources of the current scan not yet captured
   logic [N_SRC-1:0]   rem, rem_nxt, rem_left;
   logic [N_SRC-1:0]   oe_nxt;
   logic               busy_nxt, done_nxt, vld_nxt, cap;

   function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_SRC-1:0] m);
      lowest_idx = '0;
      for (int j = N_SRC - 1; j >= 0; j--) begin
         if (m[j]) lowest_idx = IDX_W'(j);
      end
   endfunction

   function automatic logic [N_SRC-1:0] idx_bit(input logic [IDX_W-1:0] i);
      idx_bit = N_SRC'(1) << i;
   endfunction

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      cur_nxt   = cur;
      rem_nxt   = rem;
      oe_nxt    = oe;
      busy_nxt  = busy;
      done_nxt  = 1'b0;
      vld_nxt   = 1'b0;
      cap       = 1'b0;
      rem_left  = rem & ~idx_bit(cur);

      case (state)
         ST_IDLE: begin
            busy_nxt = 1'b0;
            oe_nxt   = '0;
            if (start) begin
               busy_nxt = 1'b1;
               rem_nxt  = src_mask;
               if (src_mask == '0) begin
                  state_nxt = ST_FINISH;
                  done_nxt  = 1'b1;
               end else begin
                  state_nxt = ST_ENABLE;
                  cur_nxt   = lowest_idx(src_mask);
                  cnt_nxt   = CNT_LOAD;
                  oe_nxt    = idx_bit(lowest_idx(src_mask));
               end
            end
         end

         ST_ENABLE: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - 1'b1;
            end else begin
               // last settle cycle: capture now, hand the bus on this edge
               cap     = 1'b1;
               vld_nxt = 1'b1;
               rem_nxt = rem_left;
               if (rem_left == '0) begin
                  state_nxt = ST_FINISH;
                  done_nxt  = 1'b1;
                  oe_nxt    = '0;
               end else begin
`ifdef TURNAROUND_EN
                  state_nxt = ST_GAP;
                  oe_nxt    = '0;
`else
                  cur_nxt   = lowest_idx(rem_left);
                  cnt_nxt   = CNT_LOAD;
                  oe_nxt    = idx_bit(lowest_idx(rem_left));
`endif
               end
            end
         end

`ifdef TURNAROUND_EN
         ST_GAP: begin
            state_nxt = ST_ENABLE;
            cur_nxt   = lowest_idx(rem);
            cnt_nxt   = CNT_LOAD;
            oe_nxt    = idx_bit(lowest_idx(rem));
         end
`endif

         ST_FINISH: begin
            state_nxt = ST_IDLE;
            busy_nxt  = 1'b0;
            oe_nxt    = '0;
         end

         default: begin
            state_nxt = ST_IDLE;
            busy_nxt  = 1'b0;
            oe_nxt    = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         cur      <= '0;
         rem      <= '0;
         oe       <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         rd_valid <= 1'b0;
         rd_idx   <= '0;
         rd_data  <= '0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         cur      <= cur_nxt;
         rem      <= rem_nxt;
         oe       <= oe_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
         rd_valid <= vld_nxt;
         if (cap) begin
            rd_data <= bus;
            rd_idx  <= cur;
         end
      end
   end

endmodule
